// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock behind a START/BUSY/DONE handshake.
// Divisor zero takes a one-cycle path with saturated results and DIV_ZERO set.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [DW-1:0] DIVIDEND,
  input  logic [VW-1:0] DIVISOR,
  output logic [DW-1:0] QUOTIENT,
  output logic [VW-1:0] REMAINDER,
  output logic          BUSY,
  output logic          DONE,
  output logic          DIV_ZERO
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t        state;
  logic [DW-1:0] dvd_sr;
  logic [VW-1:0] dvs;
  logic [VW:0]   p;
  logic [DW-1:0] q_sr;
  logic [CW-1:0] cnt;

  logic [VW:0]   t;
  logic          ge;
  logic [VW:0]   p_next;
  logic [DW-1:0] q_next;

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    t      = {p[VW-1:0], dvd_sr[DW-1]};
    ge     = (t >= {1'b0, dvs});
    p_next = ge ? (t - {1'b0, dvs}) : t;
    q_next = {q_sr[DW-2:0], ge};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      dvd_sr    <= '0;
      dvs       <= '0;
      p         <= '0;
      q_sr      <= '0;
      cnt       <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      DIV_ZERO  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            dvd_sr <= DIVIDEND;
            dvs    <= DIVISOR;
            p      <= '0;
            q_sr   <= '0;
            cnt    <= CW'(DW - 1);
            if (DIVISOR == '0) begin
              QUOTIENT  <= '1;
              REMAINDER <= '1;
              DIV_ZERO  <= 1'b1;
              state     <= FIN;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
            end else begin
              DIV_ZERO <= 1'b0;
              state    <= RUN;
              BUSY     <= 1'b1;
              DONE     <= 1'b0;
            end
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
          end
        end
        RUN: begin
          p      <= p_next;
          q_sr   <= q_next;
          dvd_sr <= dvd_sr << 1;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            QUOTIENT  <= q_next;
            REMAINDER <= p_next[VW-1:0];
            state     <= FIN;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes expected results computed with / and %,
// an independent monitor pops and checks them whenever DONE is presented.
module tb_seq_divider;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIVIDEND = '0;
  logic [3:0] DIVISOR = '0;
  logic [7:0] QUOTIENT;
  logic [3:0] REMAINDER;
  logic       BUSY;
  logic       DONE;
  logic       DIV_ZERO;

  seq_divider #(.DW(8), .VW(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER), .BUSY(BUSY), .DONE(DONE), .DIV_ZERO(DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        dz;
    int unsigned done_edge;
    int unsigned busy;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  logic        rst_edge = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rst_edge <= RST;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: values expected to be held between completions.
  logic [7:0]  hold_q = '0;
  logic [3:0]  hold_r = '0;
  logic        hold_dz = 1'b0;
  int unsigned busy_cnt = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (rst_edge) begin
      hold_q   = '0;
      hold_r   = '0;
      hold_dz  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        check("busy_with_done", {31'd0, BUSY}, 32'd0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got DONE=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient", {24'd0, QUOTIENT}, {24'd0, e.q});
          check("remainder", {28'd0, REMAINDER}, {28'd0, e.r});
          check("div_zero", {31'd0, DIV_ZERO}, {31'd0, e.dz});
          check("done_latency", cyc, e.done_edge);
          check("busy_cycles", busy_cnt, e.busy);
          hold_q  = e.q;
          hold_r  = e.r;
          hold_dz = e.dz;
        end
        busy_cnt = 0;
      end else if (!$isunknown(BUSY)) begin
        check("hold_quotient", {24'd0, QUOTIENT}, {24'd0, hold_q});
        check("hold_remainder", {28'd0, REMAINDER}, {28'd0, hold_r});
        check("hold_div_zero", {31'd0, DIV_ZERO}, BUSY ? 32'd0 : {31'd0, hold_dz});
      end
    end
  end

  // Drive a request. b2b: caller is already inside the DONE cycle, so START lands on the FIN edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit push, input bit b2b);
    exp_t e;
    if (!b2b) begin
      @(posedge CLK);
      #1;
    end
    START    = 1'b1;
    DIVIDEND = a;
    DIVISOR  = b;
    @(posedge CLK);
    #1;
    START    = 1'b0;
    DIVIDEND = 8'($urandom);
    DIVISOR  = 4'($urandom);
    if (push) begin
      if (b == 0) begin
        e.q = 8'hFF; e.r = 4'hF; e.dz = 1'b1; e.done_edge = cyc; e.busy = 0;
      end else begin
        e.q = 8'(a / b); e.r = 4'(a % b); e.dz = 1'b0; e.done_edge = cyc + 8; e.busy = 8;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge CLK);
      #1;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  int unsigned order[4096];

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("reset_quotient", {24'd0, QUOTIENT}, 32'd0);
    check("reset_remainder", {28'd0, REMAINDER}, 32'd0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);
    check("reset_div_zero", {31'd0, DIV_ZERO}, 32'd0);

    issue(8'd225, 4'd15, 1, 0); wait_done();
    issue(8'd200, 4'd7, 1, 0);  wait_done();
    issue(8'd7, 4'd9, 1, 0);    wait_done();
    issue(8'd255, 4'd1, 1, 0);  wait_done();
    issue(8'd13, 4'd0, 1, 0);   wait_done();
    issue(8'd20, 4'd3, 1, 0);   wait_done();

    // START and operand changes during RUN must be ignored.
    issue(8'd200, 4'd7, 1, 0);
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b1; DIVIDEND = 8'd1; DIVISOR = 4'd1;
    @(posedge CLK);
    #1;
    START = 1'b0; DIVIDEND = 8'd99;
    wait_done();

    issue(8'd137, 4'd5, 1, 0);  wait_done();
    issue(8'd100, 4'd10, 1, 1); wait_done();
    issue(8'd13, 4'd0, 1, 1);   wait_done();
    issue(8'd9, 4'd0, 1, 1);    wait_done();

    // Reset in the 4th RUN cycle aborts without DONE.
    issue(8'd77, 4'd3, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_quotient", {24'd0, QUOTIENT}, 32'd0);
    check("abort_remainder", {28'd0, REMAINDER}, 32'd0);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    check("abort_div_zero", {31'd0, DIV_ZERO}, 32'd0);
    repeat (12) @(negedge CLK);
    issue(8'd50, 4'd6, 1, 0); wait_done();

    // Every operand pair in shuffled order, randomly mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int unsigned j;
      int unsigned tmp;
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = 12'(order[i]);
      issue(v[11:4], v[3:0], 1, bit'($urandom_range(1, 0)));
      wait_done();
    end

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle restoring divider that performs the inverse of the ALU multiply path. It takes an 8-bit dividend (the product width of the ALU) and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder. It produces one quotient bit per clock and uses a START/BUSY/DONE handshake. It sits beside the ALU core as the division engine for the next ALU revision.

Parameters:
DW, 8, dividend and quotient width in bits
VW, 4, divisor and remainder width in bits

Ports:
CLK  input  1  single system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request; sampled only when state is not RUN
DIVIDEND  input  DW  unsigned dividend, sampled with accepted START
DIVISOR  input  VW  unsigned divisor, sampled with accepted START
QUOTIENT  output  DW  unsigned quotient, registered
REMAINDER  output  VW  unsigned remainder, registered
BUSY  output  1  high while in RUN
DONE  output  1  one-cycle pulse, results valid
DIV_ZERO  output  1  set with DONE when divisor was 0; held until next accepted START

Behaviour:
- Interface: one clock (CLK); RST is synchronous and active-high, sampled on the CLK rising edge. There is no asynchronous reset path.
- Reset values: QUOTIENT=0, REMAINDER=0, BUSY=0, DONE=0, DIV_ZERO=0; state=IDLE; internal counter and partial remainder are 0.
- RST has priority over all other inputs. Reset mid-RUN aborts the operation; no DONE is issued.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating, BUSY=1.
  - FIN: DONE=1 for exactly one cycle.
- Acceptance rules:
  - START is accepted in IDLE or FIN and ignored in RUN.
  - START in FIN gives back-to-back operation: FIN goes directly to RUN.
- On accepting START (edge E0):
  - Latch dividend shift register and divisor.
  - Clear partial remainder P (VW+1 bits) and the quotient shift register.
  - Clear DIV_ZERO.
  - Load counter = DW-1.
- Divisor = 0 on accept:
  - Skip RUN and go to FIN.
  - At E0 set QUOTIENT = all ones (8'hFF), REMAINDER = all ones (4'hF), DIV_ZERO=1.
  - DONE is high in the cycle after E0 (latency 1).
- Each RUN cycle (restoring step):
  - T = {P[VW-1:0], dividend MSB}.
  - If T >= {1'b0,divisor}: P = T - divisor and shift in quotient bit 1.
  - Else: P = T and shift in quotient bit 0.
  - Shift the dividend register left by 1.
  - Decrement the counter.
- Leaving RUN:
  - On the RUN edge where counter=0, go to FIN.
  - At that same edge load QUOTIENT (final shift register value) and REMAINDER (P[VW-1:0]).
- Latency:
  - RUN lasts exactly DW cycles.
  - DONE is high in the cycle after edge E0+DW (DW+1 cycles after the accepting edge); 9 cycles for the defaults.
- FIN to IDLE: next edge returns to IDLE unless START is high.
- Output holding:
  - QUOTIENT, REMAINDER and DIV_ZERO hold their values until the next accepted START completes, or until reset.
  - They do not change during RUN.
- DONE and BUSY are never high in the same cycle.
- DIVIDEND and DIVISOR may change freely after acceptance; the latched copies are used.
- Arithmetic:
  - All values are unsigned.
  - Invariant: QUOTIENT*DIVISOR + REMAINDER == DIVIDEND, with REMAINDER < DIVISOR.
  - The quotient never overflows because QUOTIENT width equals DIVIDEND width.

Test Plan:
- RST held 2 cycles, then released -> all outputs 0, BUSY=0; START with 225/15 -> BUSY high 8 cycles, DONE pulse 9 cycles after accept, QUOTIENT=8'h0F, REMAINDER=0, DIV_ZERO=0.
- 200/7 -> QUOTIENT=8'h1C (28), REMAINDER=4; 7/9 -> QUOTIENT=0, REMAINDER=7; 255/1 -> QUOTIENT=8'hFF, REMAINDER=0.
- 13/0 -> DONE 1 cycle after accept, QUOTIENT=8'hFF, REMAINDER=4'hF, DIV_ZERO=1, BUSY never high; next valid op 20/3 -> DIV_ZERO clears, result 6 r 2.
- START re-pulsed with different operands during RUN, and DIVIDEND changed mid-RUN -> ignored; original result delivered on the original schedule.
- START held high through the FIN cycle with 100/10 queued -> back-to-back: second BUSY begins the cycle after DONE, second result 10 r 0.
- RST asserted in the 4th RUN cycle -> next cycle state IDLE, all outputs 0, no DONE pulse; a fresh 50/6 then completes with 8 r 2.
- Randomised sweep of all 256x16 operand pairs -> invariant holds and latency is 9 cycles (1 for divisor 0).
